// File: rtl/mux_rr_sched_8_if.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_sched_8_if
// Description : Bundle of the request/data inputs and grant/mux outputs of
//               the 8-way round-robin mux scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux_rr_sched_8_if;
    logic       en;
    logic [7:0] req;
    logic [7:0] in;
    logic [2:0] sel;
    logic [7:0] gnt;
    logic       out;
    logic       out_valid;
    logic       busy;

    // Requester side: drives requests and data, observes grants.
    modport master (
        output en, req, in,
        input  sel, gnt, out, out_valid, busy
    );

    // Scheduler side.
    modport slave (
        input  en, req, in,
        output sel, gnt, out, out_valid, busy
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_sched_8.sv
`default_nettype none
// ============================================================================
// Module      : mux_rr_sched_8
// Description : Round-robin scheduler sharing one 8:1 single-bit mux among
//               8 requesters. Each grant lasts up to HOLD cycles; the search
//               pointer rotates past the last owner so nobody starves.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_rr_sched_8 #(
    parameter int HOLD  = 4,
    parameter int CNT_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    mux_rr_sched_8_if.slave    bus
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(HOLD - 1);

    state_t           r_state, w_state_nxt;
    logic [2:0]       r_sel, w_sel_nxt;
    logic [7:0]       r_gnt, w_gnt_nxt;
    logic             r_out, w_out_nxt;
    logic             r_out_valid, w_out_valid_nxt;
    logic             r_busy, w_busy_nxt;
    logic [2:0]       r_ptr, w_ptr_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    logic       w_any_req;
    logic       w_grant_end;
    logic [2:0] w_ptr_after;
    logic [2:0] w_win_idle;
    logic [2:0] w_win_rearb;

    // First requester found scanning p, p+1, ... p+7 (3-bit index wraps).
    // Scanning downward lets the lowest offset overwrite the result last.
    function automatic logic [2:0] f_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic [2:0] win;
        win = p;
        for (int i = 7; i >= 0; i--) begin
            idx = p + 3'(i);
            if (r[idx]) win = idx;
        end
        return win;
    endfunction

    assign w_any_req   = |bus.req;
    assign w_grant_end = (r_cnt == '0) || !bus.req[r_sel] || !bus.en;
    // Rotation point after the current owner; re-arbitration uses this new
    // pointer so the owner only wins again when nobody else is asking.
    assign w_ptr_after = r_sel + 3'd1;
    assign w_win_idle  = f_pick(bus.req, r_ptr);
    assign w_win_rearb = f_pick(bus.req, w_ptr_after);

    // State register and all registered outputs, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sel       <= 3'd0;
            r_gnt       <= 8'd0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_ptr       <= 3'd0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_gnt       <= w_gnt_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_ptr       <= w_ptr_nxt;
            r_cnt       <= w_cnt_nxt;
        end
    end

    // Next-state and output logic: grant start, hold countdown, release and
    // back-to-back re-arbitration without an idle cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_gnt_nxt       = r_gnt;
        w_out_nxt       = r_out;
        w_out_valid_nxt = 1'b0;
        w_busy_nxt      = r_busy;
        w_ptr_nxt       = r_ptr;
        w_cnt_nxt       = r_cnt;

        case (r_state)
            IDLE: begin
                if (bus.en && w_any_req) begin
                    w_state_nxt = GRANT;
                    w_sel_nxt   = w_win_idle;
                    w_gnt_nxt   = 8'd1 << w_win_idle;
                    w_cnt_nxt   = c_cnt_load;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_gnt_nxt   = 8'd0;
                    w_busy_nxt  = 1'b0;
                end
            end
            GRANT: begin
                w_out_nxt       = bus.in[r_sel];
                w_out_valid_nxt = bus.req[r_sel];
                if (w_grant_end) begin
                    w_ptr_nxt = w_ptr_after;
                    if (bus.en && w_any_req) begin
                        w_sel_nxt  = w_win_rearb;
                        w_gnt_nxt  = 8'd1 << w_win_rearb;
                        w_cnt_nxt  = c_cnt_load;
                        w_busy_nxt = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = 8'd0;
                        w_busy_nxt  = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 8'd0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign bus.sel       = r_sel;
    assign bus.gnt       = r_gnt;
    assign bus.out       = r_out;
    assign bus.out_valid = r_out_valid;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/mux_rr_sched_8.md
Name: mux_rr_sched_8

Overview:
- Round-robin scheduler that shares one 8:1 single-bit mux between 8 requesters.
- Each requester owns one mux input bit and raises a request line.
- The block grants the mux to one requester at a time, drives the 3-bit select, and registers the muxed bit with a valid strobe.
- Each grant lasts up to HOLD cycles; priority rotates so no requester starves.

Parameters:
- HOLD, default 4: maximum cycles per grant; legal range 1..15.
- CNT_W, default 4: width of the hold counter; must satisfy 2^CNT_W > HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  scheduler enable; 0 blocks new grants and ends any current grant.
- req  input  8  request lines; req[i] belongs to requester i.
- in  input  8  mux data inputs; in[i] belongs to requester i.
- sel  output  3  mux select, registered.
- gnt  output  8  one-hot grant, registered; all zeros when idle.
- out  output  1  registered mux output, in[sel] sampled in the previous cycle.
- out_valid  output  1  out is valid for the granted requester.
- busy  output  1  high while in state GRANT.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset values: state=IDLE, sel=0, gnt=0, out=0, out_valid=0, busy=0, ptr=0, cnt=0.
- States: IDLE and GRANT.
- Arbitration:
  - Search order is ptr, ptr+1, ..., ptr+7, all modulo 8.
  - The first index with req[i]=1 wins.
  - Decision is combinational from the registered req/ptr; it takes effect at the next edge.
- IDLE:
  - If en=1 and req!=0: state<=GRANT, sel<=winner, gnt<=1<<winner, cnt<=HOLD-1, busy<=1.
  - Otherwise stay in IDLE with gnt=0; sel holds its last value.
- GRANT, every cycle:
  - out<=in[sel].
  - out_valid<=req[sel].
- Grant end: the grant ends at the edge where any of cnt==0, req[sel]==0 or en==0 holds. Otherwise cnt<=cnt-1.
- On grant end:
  - ptr<=sel+1 modulo 8; 7 wraps to 0.
  - If en=1 and any req is high, re-arbitrate in the same edge using the NEW ptr value, so there is no idle bubble. The previous owner may win again only if no other requester is high.
  - Otherwise: state<=IDLE, gnt<=0, busy<=0.
- out_valid when not in GRANT: in the cycle after leaving GRANT, out_valid reflects the last GRANT cycle. After that it is 0.
- Latency:
  - req rising in IDLE gives gnt/sel at the next edge.
  - The first valid out follows 1 cycle later.
  - Maximum wait for any continuously requesting port is 7*HOLD cycles plus 1 arbitration cycle.
- HOLD=1: every grant lasts exactly one cycle, and the grant rotates every cycle among active requesters.
- Requester drops req mid-grant: the grant ends immediately at that edge. That cycle's out_valid=0.
- en falls mid-grant: the grant ends at that edge and state goes to IDLE regardless of req.
- Async reset mid-grant: all outputs and ptr return to reset values immediately, without waiting for clk.
- gnt is always zero or one-hot. sel always equals the index of the set gnt bit while busy=1.

Test Plan:
- Reset then single request: rst pulse; en=1, req=8'b0000_0100, in=8'b0101_0101. Expect sel=2, gnt=8'h04 one cycle later, then out=1, out_valid=1. With HOLD=4, gnt stays 4 cycles, then is re-granted to port 2 with no bubble.
- All requesting, HOLD=4: req=8'hFF, in=8'b0101_0101. Expect grants in order 0,1,...,7,0, 4 cycles each. out alternates 1 (even ports) and 0 (odd ports). ptr wraps 7->0.
- Early release: port 5 granted; drop req[5] after 2 cycles while req[6]=1. Expect grant to move to sel=6 at that edge, with out_valid=0 for the release cycle.
- Rotation fairness: req=8'b1000_0001, HOLD=2. Expect alternating grants 0,7,0,7. Neither port waits more than 2 cycles once the other's grant ends.
- en and reset abort: mid-grant, deassert en → gnt=0 and busy=0 at the next edge. Separately, assert rst asynchronously mid-grant → sel=0, gnt=0, out=0, out_valid=0 before the next clk edge. After release, arbitration restarts from port 0.
- HOLD=1 boundary: req=8'hFF. Expect sel to increment every cycle 0..7..0, with out_valid continuously 1.
